// File: rtl/mem_stage_wait.sv
// mem_stage_wait: pipeline memory stage with an internal word-addressed data
// memory and a fixed, parameterised access latency.
//
// Any load or store raises freeze for WAIT_CYCLES cycles. The access
// completes in the following cycle: stores commit on the edge that ends it,
// and load data is valid during it. Destination, ALU result and control pass
// straight through. Write-back enables are masked while frozen so WB commits
// only on the completing cycle.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   wb_en_in        write-back enable from EXE
//   mem_r_en_in     load request
//   mem_w_en        store request (wins over a load if both are set)
//   alu_result_in   effective byte address / ALU result
//   val_rm          store data
//   dest_in         destination register index
//   wb_en_out       wb_en_in gated by ~freeze
//   mem_r_en_out    mem_r_en_in gated by ~freeze
//   alu_result_out  alu_result_in pass-through
//   mem_data        load data (valid when mem_r_en_out=1)
//   dest_out        dest_in pass-through
//   freeze          stall to upstream pipeline registers and PC
module mem_stage_wait #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 4,
   parameter int MEM_DEPTH   = 64,
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [REG_AW-1:0] dest_in,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] mem_data,
   output logic [REG_AW-1:0] dest_out,
   output logic              freeze
);

   localparam int   IDX_W   = $clog2(MEM_DEPTH);
   localparam logic WAIT_EN = (WAIT_CYCLES > 0);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [DATA_W-1:0] off;
   logic [IDX_W-1:0]  idx;
   logic              req;
   logic              wr_commit;

   // Wrap-around subtraction; out-of-window addresses simply alias.
   assign off = alu_result_in - DATA_W'(BASE_ADDR);
   assign idx = IDX_W'(off >> 2);
   assign req = mem_r_en_in | mem_w_en;

   assign freeze = ((state == S_IDLE) & req & WAIT_EN) |
                   ((state == S_WAIT) & (cnt != 4'd0));

   // Completing cycle of a store: request present and no longer stalled.
   assign wr_commit = mem_w_en & ~freeze;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req && WAIT_EN) begin
                  state <= S_WAIT;
                  cnt   <= 4'(WAIT_CYCLES - 1);
               end
            end
            S_WAIT: begin
               // cnt==0 is the completing cycle; returning to IDLE here keeps
               // the still-held inputs from retriggering an access.
               if (cnt != 4'd0) cnt   <= cnt - 4'd1;
               else             state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Reset clears the whole array and drops any pending store.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (wr_commit) begin
         mem[idx] <= val_rm;
      end
   end

   assign wb_en_out      = wb_en_in & ~freeze;
   assign mem_r_en_out   = mem_r_en_in & ~freeze;
   assign alu_result_out = alu_result_in;
   assign dest_out       = dest_in;
   // A simultaneous load+store is treated as a store: no load data.
   assign mem_data       = (mem_r_en_in & ~mem_w_en) ? mem[idx] : '0;

endmodule

// File: tb/tb_mem_stage_wait.sv
module tb_mem_stage_wait;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en_in, mem_r_en_in, mem_w_en;
   logic [31:0] alu_result_in, val_rm;
   logic [3:0]  dest_in;

   logic        wb_en_out, mem_r_en_out, freeze;
   logic [31:0] alu_result_out, mem_data;
   logic [3:0]  dest_out;

   logic        wb_en_out0, mem_r_en_out0, freeze0;
   logic [31:0] alu_result_out0, mem_data0;
   logic [3:0]  dest_out0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_stage_wait #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .mem_w_en(mem_w_en), .alu_result_in(alu_result_in), .val_rm(val_rm),
      .dest_in(dest_in), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .alu_result_out(alu_result_out), .mem_data(mem_data),
      .dest_out(dest_out), .freeze(freeze));

   mem_stage_wait #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .mem_w_en(mem_w_en), .alu_result_in(alu_result_in), .val_rm(val_rm),
      .dest_in(dest_in), .wb_en_out(wb_en_out0), .mem_r_en_out(mem_r_en_out0),
      .alu_result_out(alu_result_out0), .mem_data(mem_data0),
      .dest_out(dest_out0), .freeze(freeze0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic wb, input logic [3:0] dst);
      mem_r_en_in   = rd;
      mem_w_en      = wr;
      alu_result_in = addr;
      val_rm        = data;
      wb_en_in      = wb;
      dest_in       = dst;
   endtask

   // Advance to the next cycle: inputs change 1 time unit after the edge.
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // One full W=2 access with held inputs: freeze 1,1,0; outputs checked each cycle.
   task automatic acc(input string tag, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic wb, input logic [3:0] dst,
                      input logic chk_data, input logic [31:0] exp_data);
      drive(rd, wr, addr, data, wb, dst);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, "_freeze"}, 32'(freeze), (i == 2) ? 32'd0 : 32'd1);
         chk({tag, "_wb_en"}, 32'(wb_en_out), 32'(wb & (i == 2)));
         chk({tag, "_rd_en"}, 32'(mem_r_en_out), 32'(rd & (i == 2)));
         if (i == 2 && chk_data) begin
            chk({tag, "_data"}, mem_data, exp_data);
            chk({tag, "_dest"}, 32'(dest_out), 32'(dst));
         end
         next_cyc();
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
      next_cyc();
      next_cyc();
      rst = 1'b0;

      // Reset state with all inputs 0
      @(negedge clk);
      chk("rst_freeze", 32'(freeze), 32'd0);
      chk("rst_wb_en",  32'(wb_en_out), 32'd0);
      chk("rst_rd_en",  32'(mem_r_en_out), 32'd0);
      chk("rst_alu",    alu_result_out, 32'd0);
      chk("rst_data",   mem_data, 32'd0);
      chk("rst_dest",   32'(dest_out), 32'd0);
      next_cyc();

      // Store then load of word 1
      acc("st1", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 32'd0);
      acc("ld1", 1'b1, 1'b0, 32'd1028, 32'd0,        1'b1, 4'd5, 1'b1, 32'hDEADBEEF);

      // Back-to-back store/load, pattern 110110
      acc("st2", 1'b0, 1'b1, 32'd1032, 32'h11, 1'b0, 4'd0, 1'b0, 32'd0);
      acc("ld2", 1'b1, 1'b0, 32'd1032, 32'd0,  1'b1, 4'd7, 1'b1, 32'h11);

      // ALU-only op passes through with no stall
      drive(1'b0, 1'b0, 32'h1234, 32'd0, 1'b1, 4'd3);
      @(negedge clk);
      chk("alu_freeze", 32'(freeze), 32'd0);
      chk("alu_wb_en",  32'(wb_en_out), 32'd1);
      chk("alu_result", alu_result_out, 32'h1234);
      chk("alu_dest",   32'(dest_out), 32'd3);
      next_cyc();

      // Address wrap to word 0, then misaligned store to word 0
      acc("st_wrap", 1'b0, 1'b1, 32'd1280, 32'hA5, 1'b0, 4'd0, 1'b0, 32'd0);
      acc("ld_wrap", 1'b1, 1'b0, 32'd1024, 32'd0,  1'b1, 4'd1, 1'b1, 32'hA5);
      acc("st_mis",  1'b0, 1'b1, 32'd1026, 32'h77, 1'b0, 4'd0, 1'b0, 32'd0);
      acc("ld_mis",  1'b1, 1'b0, 32'd1024, 32'd0,  1'b1, 4'd1, 1'b1, 32'h77);

      // Load+store together: treated as store, mem_data 0
      drive(1'b1, 1'b1, 32'd1040, 32'h99, 1'b0, 4'd0);
      @(negedge clk);
      chk("both_data", mem_data, 32'd0);
      next_cyc();
      next_cyc();
      next_cyc();
      acc("ld_both", 1'b1, 1'b0, 32'd1040, 32'd0, 1'b1, 4'd2, 1'b1, 32'h99);

      // Reset in the second cycle of a store
      drive(1'b0, 1'b1, 32'd1036, 32'h55, 1'b0, 4'd0);
      @(negedge clk);
      chk("rs_freeze_t0", 32'(freeze), 32'd1);
      next_cyc();
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
      @(negedge clk);
      chk("rs_freeze_after", 32'(freeze), 32'd0);
      next_cyc();
      acc("ld_rs",   1'b1, 1'b0, 32'd1036, 32'd0, 1'b1, 4'd4, 1'b1, 32'd0);
      acc("ld_rs_0", 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 4'd4, 1'b1, 32'd0);

      // WAIT_CYCLES=0 instance: no stall, store commits on first edge
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      drive(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 4'd0);
      @(negedge clk);
      chk("w0_st_freeze", 32'(freeze0), 32'd0);
      chk("w0_st_wb_en",  32'(wb_en_out0), 32'd0);
      next_cyc();
      drive(1'b1, 1'b0, 32'd1028, 32'd0, 1'b1, 4'd5);
      @(negedge clk);
      chk("w0_ld_freeze", 32'(freeze0), 32'd0);
      chk("w0_ld_data",   mem_data0, 32'hDEADBEEF);
      chk("w0_ld_wb_en",  32'(wb_en_out0), 32'd1);
      chk("w0_ld_rd_en",  32'(mem_r_en_out0), 32'd1);
      chk("w0_ld_dest",   32'(dest_out0), 32'd5);
      next_cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
